// File: rtl/row_sweep_controller.sv
// row_sweep_controller: sweeps the active block row across the playfield, latches it on place and trims it to the row below
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   frame_tick       one-cycle pulse per video frame
//   level_go         start sweeping a new row (also restarts after a miss)
//   place            player drops the sweeping row
//   speed_frames     frames per one-column step, 0 behaves as 1
//   num_blocks       width of a freshly spawned row
//   row_x/row_width  position and width of the active row
//   draw_req         one-cycle pulse whenever row_x/row_width change
//   next_signal      one-cycle pulse when a row lands with nonzero overlap
//   game_over        held high after a row misses the stack
//   rows_placed      successful placements, saturating at 15
//   busy             high while sweeping or evaluating
module row_sweep_controller #(
    parameter int COLS  = 16,
    parameter int POS_W = 4,
    parameter int SPD_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             level_go,
    input  logic             place,
    input  logic [SPD_W-1:0] speed_frames,
    input  logic [3:0]       num_blocks,
    output logic [POS_W-1:0] row_x,
    output logic [3:0]       row_width,
    output logic             draw_req,
    output logic             next_signal,
    output logic             game_over,
    output logic [3:0]       rows_placed,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SWEEP, EVAL, FAIL} state_t;
    localparam logic [POS_W:0] COLS_W = (POS_W+1)'(COLS);
    state_t           state, state_d;
    logic [POS_W-1:0] row_x_d, prev_x, prev_x_d;
    logic [3:0]       row_width_d, prev_w, prev_w_d, rows_placed_d, spawn_w;
    logic [SPD_W-1:0] frame_cnt, frame_cnt_d, eff_speed;
    logic             dir, dir_d;
    logic             prev_valid, prev_valid_d, draw_req_d, next_signal_d, game_over_d;
    logic [POS_W:0]   row_end, prev_end, ovl_x, ovl_end, ovl_w;
    logic             step, full_row;

    assign busy = (state == SWEEP) || (state == EVAL);

    always_comb begin
        eff_speed = (speed_frames == '0) ? SPD_W'(1) : speed_frames;
        // >= keeps a live speed decrease from letting the counter run past the target
        step      = frame_tick && (frame_cnt >= eff_speed - SPD_W'(1));
        full_row  = (POS_W+1)'(row_width) == COLS_W;
        row_end   = {1'b0, row_x} + (POS_W+1)'(row_width);
        prev_end  = {1'b0, prev_x} + (POS_W+1)'(prev_w);
        ovl_x     = !prev_valid ? {1'b0, row_x} : {1'b0, (row_x > prev_x) ? row_x : prev_x};
        ovl_end   = !prev_valid ? row_end : ((row_end < prev_end) ? row_end : prev_end);
        ovl_w     = (ovl_end > ovl_x) ? ovl_end - ovl_x : '0;
        // restarting from FAIL forgets the old stack, so the spawn is always num_blocks there
        spawn_w   = (state == IDLE && prev_valid && prev_w < num_blocks) ? prev_w : num_blocks;
        state_d       = state;
        row_x_d       = row_x;
        row_width_d   = row_width;
        frame_cnt_d   = frame_cnt;
        dir_d         = dir;
        prev_valid_d  = prev_valid;
        prev_x_d      = prev_x;
        prev_w_d      = prev_w;
        rows_placed_d = rows_placed;
        game_over_d   = game_over;
        draw_req_d    = 1'b0;
        next_signal_d = 1'b0;
        case (state)
            IDLE, FAIL: begin
                if (level_go) begin
                    state_d     = SWEEP;
                    row_x_d     = '0;
                    row_width_d = spawn_w;
                    dir_d       = 1'b0;
                    frame_cnt_d = '0;
                    draw_req_d  = 1'b1;
                    game_over_d = 1'b0;
                    if (state == FAIL) begin
                        prev_valid_d  = 1'b0;
                        rows_placed_d = '0;
                    end
                end
            end
            SWEEP: begin
                if (place) begin
                    state_d = EVAL;
                end else if (frame_tick) begin
                    frame_cnt_d = step ? '0 : frame_cnt + SPD_W'(1);
                    if (step && !full_row) begin
                        // bounce at either edge, dir = 1 means moving left
                        dir_d      = (!dir && row_end == COLS_W) ? 1'b1 : (dir && row_x == '0) ? 1'b0 : dir;
                        row_x_d    = dir_d ? row_x - POS_W'(1) : row_x + POS_W'(1);
                        draw_req_d = 1'b1;
                    end
                end
            end
            EVAL: begin
                if (ovl_w != '0) begin
                    state_d       = IDLE;
                    row_x_d       = ovl_x[POS_W-1:0];
                    row_width_d   = 4'(ovl_w);
                    prev_x_d      = ovl_x[POS_W-1:0];
                    prev_w_d      = 4'(ovl_w);
                    prev_valid_d  = 1'b1;
                    rows_placed_d = (rows_placed == 4'hF) ? rows_placed : rows_placed + 4'd1;
                    next_signal_d = 1'b1;
                    draw_req_d    = 1'b1;
                end else begin
                    state_d     = FAIL;
                    game_over_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            row_x       <= '0;
            row_width   <= '0;
            frame_cnt   <= '0;
            dir         <= 1'b0;
            prev_valid  <= 1'b0;
            prev_x      <= '0;
            prev_w      <= '0;
            rows_placed <= '0;
            game_over   <= 1'b0;
            draw_req    <= 1'b0;
            next_signal <= 1'b0;
        end else begin
            state       <= state_d;
            row_x       <= row_x_d;
            row_width   <= row_width_d;
            frame_cnt   <= frame_cnt_d;
            dir         <= dir_d;
            prev_valid  <= prev_valid_d;
            prev_x      <= prev_x_d;
            prev_w      <= prev_w_d;
            rows_placed <= rows_placed_d;
            game_over   <= game_over_d;
            draw_req    <= draw_req_d;
            next_signal <= next_signal_d;
        end
    end
endmodule
